// File: rtl/ledr_pkg.sv
// Shared constants for the red-LED PWM driver: defaults, FSM encoding and
// the full-scale PWM value helper.
package ledr_pkg;
  localparam int LEDR_NUM_LEDS = 18;
  localparam int LEDR_PWM_BITS = 8;
  localparam int LEDR_PRESCALE = 50;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic int pwm_max(input int bits);
    return (1 << bits) - 1;
  endfunction
endpackage

// File: rtl/ledr_step_gen.sv
// Prescaler producing one PWM step strobe every PRESCALE clock cycles while enabled.
module ledr_step_gen
  import ledr_pkg::*;
#(
  parameter int PRESCALE = LEDR_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic step
);
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  logic [PS_W-1:0] ps_cnt_r;
  logic            at_last_s;

  assign at_last_s = (ps_cnt_r == PS_LAST);
  assign step      = en && at_last_s;

  // Prescale counter, frozen outside RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_cnt_r <= '0;
    end else if (en) begin
      ps_cnt_r <= at_last_s ? '0 : ps_cnt_r + PS_ONE;
    end else begin
      ps_cnt_r <= ps_cnt_r;
    end
  end
endmodule

// File: rtl/ledr_pwm_driver.sv
// Red-LED driver: frame-synchronous pattern/brightness shadows, PWM dimming,
// frame-aligned blinking and a registered LED drive.
module ledr_pwm_driver
  import ledr_pkg::*;
#(
  parameter int NUM_LEDS = LEDR_NUM_LEDS,
  parameter int PRESCALE = LEDR_PRESCALE,
  parameter int PWM_BITS = LEDR_PWM_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         pattern_in,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                blink_en,
  input  logic [15:0]         blink_half,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                frame_tick
);
  localparam logic [PWM_BITS-1:0] PWM_MAX = PWM_BITS'(pwm_max(PWM_BITS));
  localparam logic [PWM_BITS-1:0] PWM_ONE = PWM_BITS'(1);

  logic [0:0]          state_r;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [NUM_LEDS-1:0] pat_sh_r;
  logic [PWM_BITS-1:0] bri_sh_r;
  logic [15:0]         frm_cnt_r;
  logic                phase_r;

  logic                step_s;
  logic                boundary_s;
  logic                load_s;
  logic                on_s;
  logic [15:0]         blink_lim_s;
  logic                unused_pattern_s;

  ledr_step_gen #(.PRESCALE(PRESCALE)) u_step_gen (
    .clk   (clk),
    .reset (reset),
    .en    (state_r == ST_RUN),
    .step  (step_s)
  );

  assign boundary_s       = step_s && (pwm_cnt_r == PWM_MAX);
  assign load_s           = (state_r == ST_INIT) || boundary_s;
  assign on_s             = (bri_sh_r == PWM_MAX) || (pwm_cnt_r < bri_sh_r);
  assign blink_lim_s      = (blink_half == 16'd0) ? 16'd0 : blink_half - 16'd1;
  assign unused_pattern_s = ^(pattern_in >> NUM_LEDS);

  // FSM, PWM counter and frame-synchronous shadow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_INIT;
      pwm_cnt_r  <= '0;
      pat_sh_r   <= '0;
      bri_sh_r   <= '0;
      frame_tick <= 1'b0;
    end else begin
      state_r    <= ST_RUN;
      pwm_cnt_r  <= step_s ? pwm_cnt_r + PWM_ONE : pwm_cnt_r;
      frame_tick <= load_s;
      if (load_s) begin
        pat_sh_r <= pattern_in[NUM_LEDS-1:0];
        bri_sh_r <= brightness;
      end else begin
        pat_sh_r <= pat_sh_r;
        bri_sh_r <= bri_sh_r;
      end
    end
  end

  // Blink phase only changes on frame boundaries so it never splits a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frm_cnt_r <= 16'd0;
      phase_r   <= 1'b1;
    end else if (boundary_s) begin
      if (!blink_en) begin
        frm_cnt_r <= 16'd0;
        phase_r   <= 1'b1;
      end else if (frm_cnt_r >= blink_lim_s) begin
        frm_cnt_r <= 16'd0;
        phase_r   <= ~phase_r;
      end else begin
        frm_cnt_r <= frm_cnt_r + 16'd1;
        phase_r   <= phase_r;
      end
    end else begin
      frm_cnt_r <= blink_en ? frm_cnt_r : 16'd0;
      phase_r   <= phase_r;
    end
  end

  // Registered LED drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out <= '0;
    end else begin
      led_out <= pat_sh_r & {NUM_LEDS{on_s && phase_r}};
    end
  end
endmodule

// File: tb/tb_ledr_pwm_driver.sv
// Directed bench for ledr_pwm_driver with PRESCALE=2, PWM_BITS=8, NUM_LEDS=18
// (512-cycle frames); outputs are sampled on the falling clock edge.
module tb_ledr_pwm_driver;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pattern_in;
  logic [7:0]  brightness;
  logic        blink_en;
  logic [15:0] blink_half;
  logic [17:0] led_out;
  logic        frame_tick;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ledr_pwm_driver #(.NUM_LEDS(18), .PRESCALE(2), .PWM_BITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .pattern_in (pattern_in),
    .brightness (brightness),
    .blink_en   (blink_en),
    .blink_half (blink_half),
    .led_out    (led_out),
    .frame_tick (frame_tick)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      cyc();
      if (frame_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad_led, bad_ft;
    reset = 1'b1; pattern_in = 32'h0005AAAA; brightness = 8'hFF;
    blink_en = 1'b0; blink_half = 16'd0;
    repeat (3) @(negedge clk);
    tests++; if (led_out !== 18'h0) begin fails++; $display("FAIL reset_led: got %h want 00000", led_out); end
    tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
    reset = 1'b0;
    cyc();
    tests++; if (frame_tick !== 1'b1) begin fails++; $display("FAIL init_tick: got %b want 1", frame_tick); end
    tests++; if (led_out !== 18'h0) begin fails++; $display("FAIL init_led: got %h want 00000", led_out); end
    bad_led = 0; bad_ft = 0;
    for (int j = 2; j <= 600; j++) begin
      cyc();
      if (led_out !== 18'h1AAAA) bad_led++;
      if (frame_tick !== (j == 513)) bad_ft++;
    end
    tests++; if (bad_led != 0) begin fails++; $display("FAIL release_led: %0d cycles differ, last got %h want 1aaaa", bad_led, led_out); end
    tests++; if (bad_ft != 0) begin fails++; $display("FAIL tick_period: %0d cycles with wrong frame_tick, want single pulse 512 cycles after init", bad_ft); end
  endtask

  task automatic test_duty();
    bit ok; int bad, bad_ft, on_cnt; logic [17:0] exp;
    brightness = 8'h40; pattern_in = 32'h0003FFFF;
    wait_tick(ok);
    tests++; if (!ok) begin fails++; $display("FAIL duty_tick: got no frame_tick want one within 1200 cycles"); end
    bad = 0; bad_ft = 0; on_cnt = 0;
    for (int j = 1; j <= 512; j++) begin
      cyc();
      exp = (j <= 128) ? 18'h3FFFF : 18'h0;
      if (led_out !== exp) bad++;
      if (led_out === 18'h3FFFF) on_cnt++;
      if (frame_tick !== (j == 512)) bad_ft++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL duty: %0d cycles wrong, on for %0d cycles want 128 of 512", bad, on_cnt); end
    tests++; if (bad_ft != 0) begin fails++; $display("FAIL duty_tick_period: %0d cycles wrong frame_tick want pulse at cycle 512", bad_ft); end
  endtask

  task automatic test_mid_frame();
    bit ok; int bad; logic [17:0] exp;
    brightness = 8'hFF; pattern_in = 32'h00000001;
    wait_tick(ok);
    tests++; if (!ok) begin fails++; $display("FAIL mid_tick: got no frame_tick want one within 1200 cycles"); end
    bad = 0;
    for (int j = 1; j <= 520; j++) begin
      cyc();
      exp = (j <= 512) ? 18'h00001 : 18'h00002;
      if (led_out !== exp) begin
        bad++;
        if (bad == 1) $display("FAIL mid_frame: cycle %0d got %h want %h", j, led_out, exp);
      end
      if (j == 100) pattern_in = 32'h00000002;
    end
    tests++; if (bad != 0) fails++;
  endtask

  task automatic test_bright_zero();
    bit ok; int bad;
    brightness = 8'h00; pattern_in = 32'h0003FFFF;
    wait_tick(ok);
    tests++; if (!ok) begin fails++; $display("FAIL zero_tick: got no frame_tick want one within 1200 cycles"); end
    bad = 0;
    for (int j = 1; j <= 512; j++) begin
      cyc();
      if (led_out !== 18'h0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL bright_zero: %0d cycles lit want 0", bad); end
  endtask

  task automatic test_blink();
    bit ok; int bad2, bad1; logic [17:0] exp;
    blink_en = 1'b1; blink_half = 16'd2; brightness = 8'hFF; pattern_in = 32'h0003FFFF;
    wait_tick(ok);
    tests++; if (!ok) begin fails++; $display("FAIL blink_tick: got no frame_tick want one within 1200 cycles"); end
    bad2 = 0; bad1 = 0;
    for (int j = 1; j <= 3584; j++) begin
      cyc();
      if (j <= 512) exp = 18'h3FFFF;
      else if (j <= 1536) exp = 18'h0;
      else if (j <= 2048) exp = 18'h3FFFF;
      else if (j <= 2560) exp = 18'h0;
      else if (j <= 3072) exp = 18'h3FFFF;
      else exp = 18'h0;
      if (led_out !== exp) begin
        if (j <= 2048) bad2++; else bad1++;
      end
      if (j == 1600) blink_half = 16'd0;
    end
    tests++; if (bad2 != 0) begin fails++; $display("FAIL blink_half2: %0d cycles wrong want 2 frames on / 2 off", bad2); end
    tests++; if (bad1 != 0) begin fails++; $display("FAIL blink_half0: %0d cycles wrong want 1 frame on / 1 off", bad1); end
  endtask

  task automatic test_disable();
    bit ok; int bad; logic [17:0] exp;
    wait_tick(ok);
    tests++; if (!ok) begin fails++; $display("FAIL disable_tick: got no frame_tick want one within 1200 cycles"); end
    bad = 0;
    for (int j = 1; j <= 520; j++) begin
      cyc();
      exp = (j <= 512) ? 18'h0 : 18'h3FFFF;
      if (led_out !== exp) begin
        bad++;
        if (bad == 1) $display("FAIL blink_disable: cycle %0d got %h want %h", j, led_out, exp);
      end
      if (j == 100) blink_en = 1'b0;
    end
    tests++; if (bad != 0) fails++;
  endtask

  task automatic test_async_reset();
    bit ok;
    brightness = 8'hFF; pattern_in = 32'h00015555;
    wait_tick(ok);
    tests++; if (!ok) begin fails++; $display("FAIL areset_tick: got no frame_tick want one within 1200 cycles"); end
    repeat (111) cyc();
    tests++; if (led_out !== 18'h15555) begin fails++; $display("FAIL pre_reset_led: got %h want 15555", led_out); end
    #1 reset = 1'b1;
    #1;
    tests++; if (led_out !== 18'h0) begin fails++; $display("FAIL async_reset_led: got %h want 00000", led_out); end
    pattern_in = 32'h0002AAAA;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc();
    tests++; if (frame_tick !== 1'b1) begin fails++; $display("FAIL reinit_tick: got %b want 1", frame_tick); end
    cyc();
    tests++; if (led_out !== 18'h2AAAA) begin fails++; $display("FAIL reinit_led: got %h want 2aaaa", led_out); end
    tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL reinit_tick_pulse: got %b want 0", frame_tick); end
  endtask

  initial begin
    test_reset();
    test_duty();
    test_mid_frame();
    test_bright_zero();
    test_blink();
    test_disable();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
